// File: rtl/alu_result_serializer_pkg.sv
// Shared definitions for the ALU result serializer: FSM state encoding and default widths.
package alu_result_serializer_pkg;

  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_RES_WIDTH  = 2 * DEF_BYTE_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2,
    SEND_CS = 2'd3
  } state_t;

endpackage

// File: rtl/alu_result_serializer.sv
// Serializes 16-bit ALU results into a low-byte-first valid/ready byte stream with one pending slot.
// Optional checksum byte (low XOR high) appended when RESULT_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | nothing in flight, TX_VALID low
// SEND_LO | presenting low byte of active result
// SEND_HI | presenting high byte of active result
// SEND_CS | presenting checksum byte (RESULT_CHECKSUM_EN only)
module alu_result_serializer
  import alu_result_serializer_pkg::*;
#(
  parameter int RES_WIDTH  = DEF_RES_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [RES_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_VALID,
  output logic [BYTE_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  OVERRUN
);

`ifdef RESULT_CHECKSUM_EN
  localparam state_t LAST_ST = SEND_CS;
`else
  localparam state_t LAST_ST = SEND_HI;
`endif

  state_t                state, state_nxt;
  logic [RES_WIDTH-1:0]  active, active_nxt;
  logic [RES_WIDTH-1:0]  pend, pend_nxt;
  logic                  pend_vld, pend_vld_nxt;
  logic [BYTE_WIDTH-1:0] tx_data_nxt;
  logic                  tx_valid_nxt;
  logic                  ovr_nxt;
  logic                  xfer;
  logic                  frame_end;

  assign xfer      = TX_VALID & TX_READY;
  assign frame_end = xfer && (state == LAST_ST);
  assign BUSY      = (state != IDLE) | pend_vld;

  always_comb begin
    state_nxt    = state;
    active_nxt   = active;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    ovr_nxt      = 1'b0;

    if (state == IDLE) begin
      if (ALU_VALID) begin
        active_nxt = ALU_OUT;
        state_nxt  = SEND_LO;
      end
    end else if (frame_end) begin
      // Chain straight into the next frame so TX_VALID never bubbles.
      if (pend_vld) begin
        active_nxt = pend;
        state_nxt  = SEND_LO;
        if (ALU_VALID) pend_nxt = ALU_OUT;
        else           pend_vld_nxt = 1'b0;
      end else if (ALU_VALID) begin
        active_nxt = ALU_OUT;
        state_nxt  = SEND_LO;
      end else begin
        state_nxt = IDLE;
      end
    end else begin
      if (xfer && state == SEND_LO) state_nxt = SEND_HI;
`ifdef RESULT_CHECKSUM_EN
      else if (xfer && state == SEND_HI) state_nxt = SEND_CS;
`endif
      if (ALU_VALID) begin
        if (!pend_vld) begin
          pend_nxt     = ALU_OUT;
          pend_vld_nxt = 1'b1;
        end else begin
          ovr_nxt = 1'b1;
        end
      end
    end
  end

  // Output byte is derived from the next state so it is registered alongside it.
  always_comb begin
    tx_valid_nxt = (state_nxt != IDLE);
    case (state_nxt)
      SEND_LO: tx_data_nxt = active_nxt[BYTE_WIDTH-1:0];
      SEND_HI: tx_data_nxt = active_nxt[RES_WIDTH-1:BYTE_WIDTH];
`ifdef RESULT_CHECKSUM_EN
      SEND_CS: tx_data_nxt = active_nxt[BYTE_WIDTH-1:0] ^ active_nxt[RES_WIDTH-1:BYTE_WIDTH];
`endif
      default: tx_data_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      active   <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      state    <= state_nxt;
      active   <= active_nxt;
      pend     <= pend_nxt;
      pend_vld <= pend_vld_nxt;
      TX_DATA  <= tx_data_nxt;
      TX_VALID <= tx_valid_nxt;
      OVERRUN  <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer; expected byte streams follow RESULT_CHECKSUM_EN.
module tb_alu_result_serializer;

  logic        CLK;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        ALU_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUSY;
  logic        OVERRUN;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];

  alu_result_serializer #(.RES_WIDTH(16), .BYTE_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .ALU_VALID(ALU_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample point is 1 time unit after the edge; strobe is one cycle wide.
  task automatic step();
    @(posedge CLK);
    #1;
    ALU_VALID = 1'b0;
  endtask

  task automatic drive(input logic [15:0] v);
    ALU_OUT   = v;
    ALU_VALID = 1'b1;
  endtask

  task automatic check_stream(input string tag);
    foreach (exp_q[i]) begin
      chk({tag, "_valid"}, 16'(TX_VALID), 16'd1);
      chk({tag, "_data"},  16'(TX_DATA),  16'(exp_q[i]));
      chk({tag, "_busy"},  16'(BUSY),     16'd1);
      chk({tag, "_ovr"},   16'(OVERRUN),  16'd0);
      step();
    end
    chk({tag, "_end_valid"}, 16'(TX_VALID), 16'd0);
    chk({tag, "_end_busy"},  16'(BUSY),     16'd0);
  endtask

  initial begin
    RST = 1'b1; ALU_OUT = '0; ALU_VALID = 1'b0; TX_READY = 1'b0;
    #1;
    chk("rst_valid", 16'(TX_VALID), 16'd0);
    chk("rst_data",  16'(TX_DATA),  16'd0);
    chk("rst_busy",  16'(BUSY),     16'd0);
    chk("rst_ovr",   16'(OVERRUN),  16'd0);
    step(); step();
    RST = 1'b0;
    step();

    // Single result
    TX_READY = 1'b1;
    chk("single_pre_busy", 16'(BUSY), 16'd0);
    drive(16'hA5C3);
    step();
`ifdef RESULT_CHECKSUM_EN
    exp_q = '{8'hC3, 8'hA5, 8'h66};
`else
    exp_q = '{8'hC3, 8'hA5};
`endif
    check_stream("single");

    // Backpressure
    TX_READY = 1'b0;
    drive(16'hA5C3);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 16'(TX_VALID), 16'd1);
      chk("stall_data",  16'(TX_DATA),  16'h00C3);
      step();
    end
    TX_READY = 1'b1;
    check_stream("stall_done");

    // Back-to-back
    drive(16'h1234);
    step();
    drive(16'hBEEF);
`ifdef RESULT_CHECKSUM_EN
    exp_q = '{8'h34, 8'h12, 8'h26, 8'hEF, 8'hBE, 8'h51};
`else
    exp_q = '{8'h34, 8'h12, 8'hEF, 8'hBE};
`endif
    check_stream("b2b");

    // Overrun: stall so the third strobe finds both slots full
    TX_READY = 1'b0;
    drive(16'h0001);
    step();
    chk("ovr_first_data", 16'(TX_DATA), 16'h0001);
    drive(16'h0002);
    step();
    chk("ovr_none_yet", 16'(OVERRUN), 16'd0);
    drive(16'h0003);
    step();
    chk("ovr_pulse", 16'(OVERRUN), 16'd1);
    chk("ovr_hold_data", 16'(TX_DATA), 16'h0001);
    step();
    chk("ovr_one_cycle", 16'(OVERRUN), 16'd0);
    TX_READY = 1'b1;
`ifdef RESULT_CHECKSUM_EN
    exp_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h00, 8'h02};
`else
    exp_q = '{8'h01, 8'h00, 8'h02, 8'h00};
`endif
    check_stream("ovr_stream");

    // New result coincides with last-byte transfer, pending empty
    drive(16'hA5C3);
    step();
    chk("eof_lo", 16'(TX_DATA), 16'h00C3);
    step();
    chk("eof_hi", 16'(TX_DATA), 16'h00A5);
`ifdef RESULT_CHECKSUM_EN
    step();
    chk("eof_cs", 16'(TX_DATA), 16'h0066);
`endif
    chk("eof_last_valid", 16'(TX_VALID), 16'd1);
    drive(16'h00FF);
    step();
`ifdef RESULT_CHECKSUM_EN
    exp_q = '{8'hFF, 8'h00, 8'hFF};
`else
    exp_q = '{8'hFF, 8'h00};
`endif
    check_stream("eof");

    // Reset mid-frame after low byte transfers
    drive(16'h1234);
    step();
    step();
    chk("mid_hi", 16'(TX_DATA), 16'h0012);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_valid", 16'(TX_VALID), 16'd0);
    chk("mid_rst_busy",  16'(BUSY),     16'd0);
    chk("mid_rst_ovr",   16'(OVERRUN),  16'd0);
    chk("mid_rst_data",  16'(TX_DATA),  16'd0);
    step();
    RST = 1'b0;
    chk("post_rst_valid", 16'(TX_VALID), 16'd0);
    drive(16'h5A5A);
    step();
`ifdef RESULT_CHECKSUM_EN
    exp_q = '{8'h5A, 8'h5A, 8'h00};
`else
    exp_q = '{8'h5A, 8'h5A};
`endif
    check_stream("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream consumer of the ALU. Captures each 16-bit result on the ALU valid strobe and emits it as a byte stream, low byte first, over a valid/ready handshake toward the UART TX path.
- Holds one frame in flight plus one pending result, so back-to-back ALU results are absorbed without loss.
- Flags overrun when a third result arrives while both slots are full.

Parameters:
- RES_WIDTH, 16, width of the incoming ALU result; must equal 2*BYTE_WIDTH.
- BYTE_WIDTH, 8, width of each output byte.

Ports:
- CLK  input  1  single clock.
- RST  input  1  asynchronous, active-high reset.
- ALU_OUT  input  RES_WIDTH  result from the ALU.
- ALU_VALID  input  1  result-valid strobe; every high cycle is a new result.
- TX_DATA  output  BYTE_WIDTH  byte presented downstream.
- TX_VALID  output  1  TX_DATA is valid.
- TX_READY  input  1  downstream accepts the byte.
- BUSY  output  1  a frame is in flight or a result is pending.
- OVERRUN  output  1  one-cycle pulse when a result is dropped.

Behaviour:
- Reset (async, RST=1): state IDLE, pending slot empty, all registers clear. TX_DATA=0, TX_VALID=0, BUSY=0, OVERRUN=0. This applies immediately, including mid-frame; a partially sent frame is abandoned.
- Registered outputs: TX_VALID, TX_DATA and OVERRUN are registered. BUSY is combinational: (state!=IDLE) or pending valid.
- Transfer rule: a byte transfers on a CLK edge where TX_VALID=1 and TX_READY=1.
- Hold rule: while TX_VALID=1 and TX_READY=0, TX_DATA and TX_VALID hold stable. TX_VALID never drops without a transfer, except on reset.
- FSM state IDLE: TX_VALID=0. On ALU_VALID, capture ALU_OUT into the active register and go to SEND_LO. Latency is 1: TX_VALID=1 with the low byte on the cycle after ALU_VALID.
- FSM state SEND_LO: TX_DATA=active[BYTE_WIDTH-1:0]. On transfer, go to SEND_HI.
- FSM state SEND_HI: TX_DATA=active[RES_WIDTH-1:BYTE_WIDTH]. On transfer, end the frame (the checksum state is described under Optional Feature).
- End of frame (last byte transferred):
  - If pending is valid: pending moves to active and the FSM goes to SEND_LO with no bubble; TX_VALID stays 1.
  - If pending is valid and ALU_VALID arrives the same cycle: the new result enters the freed pending slot.
  - If pending is empty and ALU_VALID arrives the same cycle: capture directly into active and go to SEND_LO with no bubble.
  - If pending is empty and no ALU_VALID: go to IDLE; TX_VALID=0 next cycle.
- ALU_VALID while state!=IDLE and not at the end of a frame:
  - Pending empty: capture into pending.
  - Pending full: drop the result; pending keeps its older value; OVERRUN=1 for the next cycle only.
- No ordering change: results are always emitted in arrival order.
- Upstream holds its valid strobe high for as long as its enable is high. Continuous strobing therefore overruns by design; upstream sequencing must space results at least one frame apart.

Optional Feature:
- Macro: RESULT_CHECKSUM_EN.
- Defined: adds state SEND_CS after SEND_HI. It sends TX_DATA = low byte XOR high byte of the active result, under the same handshake rules. The end-of-frame logic moves to the SEND_CS transfer. Frame length is 3 bytes.
- Undefined: SEND_CS does not exist and the frame is 2 bytes.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, SEND_LO=2'd1, SEND_HI=2'd2, SEND_CS=2'd3);
  - the default BYTE_WIDTH and RES_WIDTH.
- No sub-module is needed. The pending slot is a single register plus a valid bit, kept inline.

Test Plan:
- Single result: reset, ALU_OUT=16'hA5C3 with ALU_VALID for 1 cycle, TX_READY=1. Required: TX_DATA=8'hC3 then 8'hA5 on consecutive cycles, TX_VALID low afterwards, BUSY 1 throughout then 0. With checksum enabled, a third byte 8'h66 follows.
- Backpressure: TX_READY=0 for 5 cycles after TX_VALID rises. Required: TX_DATA holds 8'hC3 and TX_VALID holds 1 through the stall, then the frame completes normally.
- Back-to-back: results 16'h1234 then 16'hBEEF, ALU_VALID on consecutive cycles, TX_READY=1. Required: byte stream 34,12,EF,BE with no TX_VALID gap and no OVERRUN.
- Overrun: three results on consecutive cycles (16'h0001, 16'h0002, 16'h0003). Required: OVERRUN pulses once; the stream is 01,00,02,00; 16'h0003 is lost.
- End-of-frame coincidence: ALU_VALID=16'h00FF on the same cycle the last byte transfers, pending empty. Required: the next cycle shows TX_DATA=8'hFF with TX_VALID=1 and no bubble.
- Reset mid-frame: assert RST after the low byte transfers. Required: TX_VALID, BUSY and OVERRUN go to 0 asynchronously. After release, a new result 16'h5A5A is emitted as 5A,5A.
